// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler for the frame FIFO: drains fixed-length bursts onto the
// DDR write-channel bus with frame-relative addressing and end-of-frame flush.
module fifo_burst_rd_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 13,
    parameter int BURST_LEN   = 16,
    parameter int ADDR_WIDTH  = 28
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [15:0]            cfg_frame_bursts,
    input  logic                   flush,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    output logic                   bus_req,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [7:0]             bus_len,
    input  logic                   bus_ack,
    output logic                   bus_wvalid,
    output logic [DATA_WIDTH-1:0]  bus_wdata,
    output logic                   bus_wlast,
    input  logic                   bus_wready,
    output logic                   frame_done,
    output logic                   busy
);

    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [7:0]            FULL_LEN    = 8'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   offset_q, offset_d;
    logic [15:0]             count_q, count_d;
    logic                    flush_pending_q, flush_pending_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [7:0]              bus_len_q, bus_len_d;
    logic                    bus_req_q, bus_req_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              issued_q, issued_d;
    logic [7:0]              sent_q, sent_d;
    logic                    inflight_q, inflight_d;
    logic [1:0]              occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;

    logic                    pop;
    logic                    push;
    logic                    last_beat;
    logic                    rd_en;
    logic                    close;
    logic [1:0]              occ_after_pop;
    logic [15:0]             count_inc;

    // Space check counts the read in flight, so a word is never returned into a full buffer.
    assign pop           = (occ_q != 2'd0) && bus_wready;
    assign push          = inflight_q;
    assign last_beat     = (sent_q == bus_len_q - 8'd1);
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign rd_en         = (state_q == DATA) && (issued_q < bus_len_q) && !fifo_rd_empty &&
                           (({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2);
    assign count_inc     = count_q + 16'd1;

    always_comb begin
        state_d         = state_q;
        offset_d        = offset_q;
        count_d         = count_q;
        flush_pending_d = flush_pending_q | flush;
        bus_addr_d      = bus_addr_q;
        bus_len_d       = bus_len_q;
        bus_req_d       = bus_req_q;
        frame_done_d    = 1'b0;
        close           = 1'b0;
        issued_d        = issued_q + {7'd0, rd_en};
        sent_d          = sent_q + {7'd0, pop};
        inflight_d      = rd_en;
        occ_d           = occ_after_pop + {1'b0, push};
        buf0_d          = pop ? buf1_q : buf0_q;
        buf1_d          = buf1_q;
        if (push) begin
            if (occ_after_pop == 2'd0) begin
                buf0_d = fifo_rd_data;
            end else begin
                buf1_d = fifo_rd_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN)) begin
                    state_d    = REQ;
                    bus_req_d  = 1'b1;
                    bus_addr_d = cfg_base_addr + offset_q;
                    bus_len_d  = FULL_LEN;
                    issued_d   = 8'd0;
                    sent_d     = 8'd0;
                end else if (flush_pending_q && (fifo_rd_water_level != '0)) begin
                    state_d    = REQ;
                    bus_req_d  = 1'b1;
                    bus_addr_d = cfg_base_addr + offset_q;
                    bus_len_d  = 8'(fifo_rd_water_level);
                    issued_d   = 8'd0;
                    sent_d     = 8'd0;
                end else if (flush_pending_q) begin
                    close = 1'b1;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (pop && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus_len_q == FULL_LEN) begin
                    offset_d = offset_q + BURST_BYTES;
                    count_d  = count_inc;
                    if ((cfg_frame_bursts != 16'd0) && (count_inc == cfg_frame_bursts)) begin
                        close = 1'b1;
                    end
                end else begin
                    close = 1'b1;
                end
            end
        endcase

        // A flush landing on the closing cycle belongs to the next frame.
        if (close) begin
            offset_d        = '0;
            count_d         = 16'd0;
            flush_pending_d = flush;
            frame_done_d    = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q         <= IDLE;
            offset_q        <= '0;
            count_q         <= 16'd0;
            flush_pending_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_len_q       <= 8'd0;
            bus_req_q       <= 1'b0;
            frame_done_q    <= 1'b0;
            issued_q        <= 8'd0;
            sent_q          <= 8'd0;
            inflight_q      <= 1'b0;
            occ_q           <= 2'd0;
            buf0_q          <= '0;
            buf1_q          <= '0;
        end else begin
            state_q         <= state_d;
            offset_q        <= offset_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            bus_addr_q      <= bus_addr_d;
            bus_len_q       <= bus_len_d;
            bus_req_q       <= bus_req_d;
            frame_done_q    <= frame_done_d;
            issued_q        <= issued_d;
            sent_q          <= sent_d;
            inflight_q      <= inflight_d;
            occ_q           <= occ_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign bus_req    = bus_req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_len    = bus_len_q;
    assign bus_wvalid = (occ_q != 2'd0);
    assign bus_wdata  = buf0_q;
    assign bus_wlast  = (occ_q != 2'd0) && last_beat;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
`timescale 1ns/1ps
// Directed bench for fifo_burst_rd_ctrl: queue-based FIFO model, a table of bursts,
// and hand sequences for mid-burst underflow and reset.
module tb_fifo_burst_rd_ctrl;
    localparam int DW = 32;
    localparam int LW = 13;
    localparam int BL = 16;
    localparam int AW = 28;
    localparam int NV = 13;

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b1;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [15:0]   cfg_frame_bursts = 16'd0;
    logic          flush = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic [LW-1:0] fifo_rd_water_level = '0;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_len;
    logic          bus_ack = 1'b0;
    logic          bus_wvalid;
    logic [DW-1:0] bus_wdata;
    logic          bus_wlast;
    logic          bus_wready = 1'b1;
    logic          frame_done;
    logic          busy;

    fifo_burst_rd_ctrl #(
        .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst),
        .cfg_base_addr(cfg_base_addr), .cfg_frame_bursts(cfg_frame_bursts), .flush(flush),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_water_level(fifo_rd_water_level),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_len(bus_len), .bus_ack(bus_ack),
        .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata), .bus_wlast(bus_wlast),
        .bus_wready(bus_wready), .frame_done(frame_done), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: data appears the cycle after rd_en; status refreshed 1ns after each edge.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] push_ctr = '0;
    logic [DW-1:0] exp_ctr = '0;
    bit            level_force = 1'b0;

    task automatic fifo_status();
        fifo_rd_empty       = (fq.size() == 0);
        fifo_rd_water_level = level_force ? LW'(BL) : LW'(fq.size());
    endtask

    task automatic fifo_push(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(push_ctr);
            push_ctr++;
        end
        fifo_status();
    endtask

    always @(posedge rd_clk) begin
        if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
        #1 fifo_status();
    end

    int wmode = 0;
    always @(posedge rd_clk) begin
        #1;
        case (wmode)
            1:       bus_wready = ~bus_wready;
            2:       bus_wready = 1'($urandom_range(0, 1));
            default: bus_wready = 1'b1;
        endcase
    end

    int beat = 0, last_cnt = 0, fd_cnt = 0, req_cnt = 0, rd_empty_cnt = 0, cur_len = 16;
    always @(negedge rd_clk) begin
        if (!rd_rst) begin
            if (fifo_rd_en && fifo_rd_empty) rd_empty_cnt++;
            if (frame_done) fd_cnt++;
            if (bus_req && bus_ack) req_cnt++;
            if (bus_wvalid && bus_wready) begin
                chk("wdata", bus_wdata, exp_ctr);
                chk("wlast", 32'(bus_wlast), 32'(beat == cur_len - 1));
                exp_ctr++;
                beat++;
                if (bus_wlast) last_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_req(input logic [AW-1:0] ea, input int el);
        int t = 0;
        while (!bus_req && t < 400) begin tick(); t++; end
        chk("req_seen", 32'(bus_req), 32'd1);
        chk("bus_addr", 32'(bus_addr), 32'(ea));
        chk("bus_len", 32'(bus_len), 32'(el));
        tick();
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("req_drop", 32'(bus_req), 32'd0);
    endtask

    task automatic finish_burst(input int el, input int edone, input int fd0);
        int t = 0;
        while (last_cnt == 0 && t < 600) begin tick(); t++; end
        t = 0;
        while (busy && t < 20) begin tick(); t++; end
        tick();
        tick();
        chk("beats", 32'(beat), 32'(el));
        chk("wlast_cnt", 32'(last_cnt), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("frame_done", 32'(fd_cnt - fd0), 32'(edone));
        chk("rd_while_empty", 32'(rd_empty_cnt), 32'd0);
    endtask

    typedef struct {
        int            nwords;
        bit            do_flush;
        logic [AW-1:0] base;
        logic [15:0]   fbursts;
        int            wm;
        logic [AW-1:0] exp_addr;
        int            exp_len;
        int            exp_done;
    } vec_t;

    vec_t vt[NV];

    initial begin
        int fd0, rq0, t;
        // Offset advances 0x40 per full burst; closes reset it to 0.
        vt[0]  = '{16, 1'b0, 28'h100,     16'd3, 0, 28'h100,  16, 0};
        vt[1]  = '{16, 1'b0, 28'h100,     16'd3, 0, 28'h140,  16, 0};
        vt[2]  = '{16, 1'b0, 28'h100,     16'd3, 0, 28'h180,  16, 1};
        vt[3]  = '{16, 1'b0, 28'h100,     16'd0, 0, 28'h100,  16, 0};
        vt[4]  = '{5,  1'b1, 28'h100,     16'd0, 0, 28'h140,  5,  1};
        vt[5]  = '{16, 1'b0, 28'h100,     16'd0, 1, 28'h100,  16, 0};
        vt[6]  = '{16, 1'b0, 28'h100,     16'd0, 2, 28'h140,  16, 0};
        vt[7]  = '{16, 1'b0, 28'h2000,    16'd0, 0, 28'h2080, 16, 0};
        vt[8]  = '{0,  1'b1, 28'h2000,    16'd0, 0, 28'h0,    0,  1};
        vt[9]  = '{16, 1'b0, 28'h2000,    16'd0, 0, 28'h2000, 16, 0};
        vt[10] = '{16, 1'b0, 28'hFFFFFC0, 16'd0, 0, 28'h0,    16, 0};
        vt[11] = '{16, 1'b0, 28'h300,     16'd4, 0, 28'h380,  16, 0};
        vt[12] = '{16, 1'b0, 28'h300,     16'd4, 0, 28'h3C0,  16, 1};

        tick();
        tick();
        chk("rst_ctrl", 32'({bus_req, bus_wvalid, bus_wlast, fifo_rd_en, frame_done, busy}), 32'd0);
        rd_rst = 1'b0;
        tick();
        chk("post_rst_ctrl", 32'({bus_req, bus_wvalid, bus_wlast, fifo_rd_en, frame_done, busy}), 32'd0);
        chk("post_rst_addr", 32'(bus_addr), 32'd0);
        chk("post_rst_len", 32'(bus_len), 32'd0);

        for (int i = 0; i < NV; i++) begin
            cfg_base_addr    = vt[i].base;
            cfg_frame_bursts = vt[i].fbursts;
            wmode            = vt[i].wm;
            cur_len          = vt[i].exp_len;
            beat             = 0;
            last_cnt         = 0;
            fd0              = fd_cnt;
            rq0              = req_cnt;
            fifo_push(vt[i].nwords);
            if (vt[i].do_flush) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            if (vt[i].exp_len != 0) begin
                do_req(vt[i].exp_addr, vt[i].exp_len);
                finish_burst(vt[i].exp_len, vt[i].exp_done, fd0);
            end else begin
                tick();
                tick();
                tick();
                chk("close_in_place", 32'(fd_cnt - fd0), 32'(vt[i].exp_done));
                chk("no_req", 32'(req_cnt - rq0), 32'd0);
                chk("busy_idle", 32'(busy), 32'd0);
            end
            $display("vec %0d: addr=0x%0h len=%0d beats=%0d frame_done=%0d",
                     i, bus_addr, bus_len, beat, fd_cnt - fd0);
        end

        // Underflow mid-burst: level reports 16 while only 8 words are present.
        cfg_base_addr    = 28'h500;
        cfg_frame_bursts = 16'd0;
        wmode            = 0;
        cur_len          = 16;
        beat             = 0;
        last_cnt         = 0;
        fd0              = fd_cnt;
        level_force      = 1'b1;
        fifo_push(8);
        do_req(28'h500, 16);
        level_force = 1'b0;
        fifo_status();
        t = 0;
        while (beat < 8 && t < 100) begin tick(); t++; end
        repeat (5) tick();
        chk("gap_wvalid", 32'(bus_wvalid), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_beats", 32'(beat), 32'd8);
        repeat (5) tick();
        fifo_push(8);
        finish_burst(16, 0, fd0);
        $display("gap: beats=%0d wlast_count=%0d", beat, last_cnt);

        // Reset while the 7th word is on the bus.
        beat     = 0;
        last_cnt = 0;
        fifo_push(16);
        do_req(28'h540, 16);
        t = 0;
        while (beat < 6 && t < 100) begin tick(); t++; end
        rd_rst = 1'b1;
        @(negedge rd_clk);
        chk("midrst_ctrl", 32'({bus_req, bus_wvalid, bus_wlast, fifo_rd_en, frame_done, busy}), 32'd0);
        chk("midrst_addr", 32'(bus_addr), 32'd0);
        chk("midrst_len", 32'(bus_len), 32'd0);
        chk("midrst_wdata", bus_wdata, 32'd0);
        fq.delete();
        fifo_status();
        exp_ctr = push_ctr;
        tick();
        tick();
        rd_rst   = 1'b0;
        beat     = 0;
        last_cnt = 0;
        fd0      = fd_cnt;
        tick();
        fifo_push(16);
        do_req(28'h500, 16);
        finish_burst(16, 0, fd0);
        $display("reset: new burst addr=0x%0h beats=%0d", bus_addr, beat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
